spi_flash_target: RTL and testbench
===================================

// Module: spi_flash_target
// PURPOSE
//  SPI mode-0 responder emulating the EN25F80 command subset driven by flash_ctrl (READ, RDSR, RDID, opt. PAGE PROGRAM).
//  Serves a byte-wide local memory port to an external SPI master; system-clock oversampled, no SCK clock domain.
//  Used as loopback target for flash_ctrl in simulation and as an on-board boot-image source.
// PARAMETERS
//  MEM_AW    16         local memory byte-address width; SPI address bits above MEM_AW ignored
//  JEDEC_ID  24'h1C3114 3-byte ID returned by RDID (0x9F), MSB first
//  SYNC_LEN  2          synchroniser depth on spi_clk_i / spi_cs_n_i / spi_di_i (>=2)
// PORTS
//  clk           in  1       system clock; SCK must be <= clk/8
//  rst_n         in  1       asynchronous reset, active low
//  spi_clk_i     in  1       SCK from master
//  spi_cs_n_i    in  1       chip select, active low
//  spi_di_i      in  1       MOSI (data master -> target)
//  spi_do_o      out 1       MISO (data target -> master)
//  spi_do_oe_o   out 1       MISO output enable; tri-state at top level
//  mem_addr_o    out MEM_AW  local memory byte address
//  mem_rd_o      out 1       1-cycle read strobe; mem_rdata_i valid exactly 1 clk later
//  mem_rdata_i   in  8       read data
//  mem_wr_o      out 1       1-cycle write strobe (SPI_TGT_WRITE_EN only, else tied 0)
//  mem_wdata_o   out 8       write data
//  busy_o        out 1       transaction in progress (synchronised CS asserted)
// BEHAVIOUR
//  Reset: all outputs 0 except spi_do_o=0, spi_do_oe_o=0; FSM=IDLE; bit counter 0.
//  Inputs pass SYNC_LEN flops; rise/fall of SCK and CS detected on synchronised copies (latency SYNC_LEN+1 clk).
//  Sample spi_di_i on SCK rise; update spi_do_o on SCK fall; MSB first. spi_do_oe_o=1 only in data-out states.
//  FSM: IDLE -CS fall-> CMD (8 bits)
//   CMD: 0x03 -> ADDR; 0x05 -> STAT; 0x9F -> ID; 0x02 -> ADDR (write build) / IGNORE; other -> IGNORE.
//   ADDR: 24 bits, keep low MEM_AW. On 24th rise: READ path pulses mem_rd_o next clk; byte loaded to shifter
//    before following SCK fall -> RD_DATA. Write path -> WR_DATA.
//   RD_DATA: shift byte; on 8th rise addr+1 (wraps mod 2^MEM_AW), prefetch next byte via mem_rd_o; unbounded.
//   WR_DATA: each 8th rise -> mem_wr_o 1 clk with assembled byte at current addr, then addr+1 (wraps).
//   STAT: returns 8'h00 repeatedly (never busy). ID: JEDEC_ID bytes 2,1,0 then repeats 0x00.
//   IGNORE: MISO oe=0, absorb clocks until CS rise.
//  CS rise in any state -> IDLE next clk; partial byte discarded, no mem_wr_o; oe drops same clk.
//  SCK edges while CS high ignored. CS fall during IDLE restarts bit counter even if SCK toggles simultaneously.
//  Reset mid-transaction: immediate IDLE; master must re-assert CS to start again.
//  mem_rd_o and mem_wr_o never asserted in same cycle; at most one strobe per byte.
// CONFIGURATION
//  SPI_TGT_WRITE_EN defined: 0x02 PAGE PROGRAM accepted (no WREN needed, no page wrap, addr wraps mod 2^MEM_AW).
//  Not defined: 0x02 -> IGNORE, mem_wr_o/mem_wdata_o constant 0, write logic removed.
// STRUCTURE
//  spi_flash_defs.vh (shared with flash_ctrl): opcode constants CMD_READ/CMD_PP/CMD_RDSR/CMD_RDID, FSM state encodings.
//  Sub-module spi_tgt_sync: SYNC_LEN flop chains + edge detect; outputs sck_rise, sck_fall, cs_act, cs_start, cs_end, di_s.
//  Top of block: FSM, 8-bit shifter, 5-bit bit counter, MEM_AW address counter.
// TESTING
//  1 Reset: rst_n low mid-READ byte -> spi_do_oe_o=0, busy_o=0, no mem strobes; next CS fall runs clean READ.
//  2 READ 0x03 addr 0x000010, mem[0x10..0x12]=A5,3C,FF, 24 SCKs -> MISO A5 3C FF, 3 mem_rd_o pulses, addrs 0x10-0x12.
//  3 Wrap: READ addr 0x00FFFF (MEM_AW=16), 2 bytes -> mem_addr_o 0xFFFF then 0x0000; addr 0x12FFFF -> same.
//  4 RDID 0x9F, 32 SCKs -> MISO 1C 31 14 00; RDSR 0x05, 16 SCKs -> 00 00; opcode 0xAB -> oe stays 0.
//  5 WRITE_EN: 0x02 addr 0x000100 bytes 11,22 + 3 bits then CS rise -> exactly 2 mem_wr_o (0x100=11, 0x101=22).
//  6 Without WRITE_EN: same stimulus as 5 -> zero mem_wr_o, oe=0; CS rise -> IDLE within 1 clk of sync CS.

Source files
------------

// File: rtl/spi_flash_target_pkg.sv
// Shared opcode constants and FSM state encoding for the SPI flash responder.
package spi_flash_target_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRdData,
        StWrData,
        StStat,
        StId,
        StIgnore
    } state_e;

    // States in which the target drives MISO.
    function automatic logic is_dout(state_e s);
        return (s == StRdData) || (s == StStat) || (s == StId);
    endfunction

endpackage

// File: rtl/spi_flash_target_sync.sv
// Synchronises SCK/CS/MOSI into the system clock domain and detects SCK and CS edges.
module spi_flash_target_sync #(
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk_i,
    input  logic spi_cs_n_i,
    input  logic spi_di_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_act_o,
    output logic cs_start_o,
    output logic cs_end_o,
    output logic di_s_o
);

    logic [SYNC_LEN-1:0] sck_q, cs_n_q, di_q;
    logic                sck_prev_q, cs_n_prev_q;

    // CS chain resets to "asserted" so a CS held low across reset creates no start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q       <= '0;
            cs_n_q      <= '0;
            di_q        <= '0;
            sck_prev_q  <= 1'b0;
            cs_n_prev_q <= 1'b0;
        end else begin
            sck_q       <= {sck_q[SYNC_LEN-2:0], spi_clk_i};
            cs_n_q      <= {cs_n_q[SYNC_LEN-2:0], spi_cs_n_i};
            di_q        <= {di_q[SYNC_LEN-2:0], spi_di_i};
            sck_prev_q  <= sck_q[SYNC_LEN-1];
            cs_n_prev_q <= cs_n_q[SYNC_LEN-1];
        end
    end

    assign sck_rise_o = sck_q[SYNC_LEN-1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_q[SYNC_LEN-1] & sck_prev_q;
    assign cs_act_o   = ~cs_n_q[SYNC_LEN-1];
    assign cs_start_o = ~cs_n_q[SYNC_LEN-1] & cs_n_prev_q;
    assign cs_end_o   = cs_n_q[SYNC_LEN-1] & ~cs_n_prev_q;
    assign di_s_o     = di_q[SYNC_LEN-1];

endmodule

// File: rtl/spi_flash_target.sv
// SPI mode-0 flash responder (READ/RDSR/RDID) serving a byte-wide memory port.
// Define SPI_TGT_WRITE_EN to also accept PAGE PROGRAM (0x02).
module spi_flash_target
    import spi_flash_target_pkg::*;
#(
    parameter int unsigned MEM_AW   = 16,
    parameter logic [23:0] JEDEC_ID = 24'h1C3114,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_di_i,
    output logic              spi_do_o,
    output logic              spi_do_oe_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              mem_wr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o
);

    localparam logic [MEM_AW-1:0] AddrOne = MEM_AW'(1);

    logic sck_rise, sck_fall, cs_act, cs_start, cs_end, di_s;

    spi_flash_target_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk_i  (spi_clk_i),
        .spi_cs_n_i (spi_cs_n_i),
        .spi_di_i   (spi_di_i),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_act_o   (cs_act),
        .cs_start_o (cs_start),
        .cs_end_o   (cs_end),
        .di_s_o     (di_s)
    );

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        out_q, out_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic              do_q, do_d;
    logic              rd_q, rd_d;
    logic              load_q;
    logic [7:0]        rx_byte;
    logic              wr_mode;

    assign rx_byte = {shift_q[6:0], di_s};

`ifdef SPI_TGT_WRITE_EN
    logic       wr_mode_q, wr_mode_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;

    assign wr_mode     = wr_mode_q;
    assign mem_wr_o    = wr_q;
    assign mem_wdata_o = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_mode_q <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= 8'h00;
        end else begin
            wr_mode_q <= wr_mode_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
        end
    end
`else
    assign wr_mode     = 1'b0;
    assign mem_wr_o    = 1'b0;
    assign mem_wdata_o = 8'h00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            addr_q    <= '0;
            id_idx_q  <= '0;
            do_q      <= 1'b0;
            rd_q      <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            addr_q    <= addr_d;
            id_idx_q  <= id_idx_d;
            do_q      <= do_d;
            rd_q      <= rd_d;
            load_q    <= rd_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        out_d     = out_q;
        addr_d    = addr_q;
        id_idx_d  = id_idx_q;
        do_d      = do_q;
        rd_d      = 1'b0;
`ifdef SPI_TGT_WRITE_EN
        wr_mode_d = wr_mode_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        // Address advances once the write strobe has presented the current address.
        if (wr_q) addr_d = addr_q + AddrOne;
`endif
        if (cs_end || !cs_act) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            do_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_start) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = StIgnore;
                            if (rx_byte == CMD_READ) begin
                                state_d = StAddr;
`ifdef SPI_TGT_WRITE_EN
                                wr_mode_d = 1'b0;
                            end else if (rx_byte == CMD_PP) begin
                                state_d   = StAddr;
                                wr_mode_d = 1'b1;
`endif
                            end else if (rx_byte == CMD_RDSR) begin
                                state_d = StStat;
                                out_d   = 8'h00;
                            end else if (rx_byte == CMD_RDID) begin
                                state_d  = StId;
                                out_d    = JEDEC_ID[23:16];
                                id_idx_d = 2'd1;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        // Upper address bits fall off the top of the shift.
                        addr_d    = {addr_q[MEM_AW-2:0], di_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (wr_mode) begin
                                state_d = StWrData;
                            end else begin
                                state_d = StRdData;
                                rd_d    = 1'b1;
                            end
                        end
                    end
                end
                StRdData, StStat, StId: begin
                    if (sck_fall) begin
                        do_d  = out_q[7];
                        out_d = {out_q[6:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q[2:0] == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == StRdData) begin
                                addr_d = addr_q + AddrOne;
                                rd_d   = 1'b1;
                            end else if (state_q == StStat) begin
                                out_d = 8'h00;
                            end else begin
                                case (id_idx_q)
                                    2'd1:    out_d = JEDEC_ID[15:8];
                                    2'd2:    out_d = JEDEC_ID[7:0];
                                    default: out_d = 8'h00;
                                endcase
                                id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                            end
                        end
                    end
                end
                StWrData: begin
`ifdef SPI_TGT_WRITE_EN
                    if (sck_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            wr_d      = 1'b1;
                            wdata_d   = rx_byte;
                        end
                    end
`endif
                end
                StIgnore: ;
                default:  state_d = StIdle;
            endcase
        end
        // Memory read data lands one clock after the strobe, well before the next SCK fall.
        if (load_q) out_d = mem_rdata_i;
    end

    assign spi_do_o    = do_q;
    assign spi_do_oe_o = is_dout(state_q);
    assign mem_addr_o  = addr_q;
    assign mem_rd_o    = rd_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_flash_target.sv
// Directed bench for spi_flash_target: SPI master tasks, byte memory model and strobe logs.
module tb_spi_flash_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        di = 1'b0;
    logic        miso, miso_oe, mem_rd, mem_wr, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;

    logic [7:0]  mem [0:65535];
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, oe_cnt = 0;
    logic [15:0] rd_log [0:63];
    logic [15:0] wr_alog [0:63];
    logic [7:0]  wr_dlog [0:63];
    int          nvec = 0, nerr = 0;

    spi_flash_target #(.MEM_AW(16), .JEDEC_ID(24'h1C3114), .SYNC_LEN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk_i   (sck),
        .spi_cs_n_i  (cs_n),
        .spi_di_i    (di),
        .spi_do_o    (miso),
        .spi_do_oe_o (miso_oe),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_rdata_i (mem_rdata),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_log[rd_cnt[5:0]] <= mem_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (mem_wr) begin
            wr_alog[wr_cnt[5:0]] <= mem_addr;
            wr_dlog[wr_cnt[5:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
        if (miso_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK period (SCK = clk/10); MISO sampled at the rising edge.
    task automatic bit_x(input logic b, output logic o);
        di = b;
        #50;
        o = miso;
        sck = 1'b1;
        #50;
        sck = 1'b0;
    endtask

    task automatic byte_x(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 0; i < 8; i++) begin
            bit_x(tx[7-i], b);
            rx[7-i] = b;
        end
    endtask

    task automatic cmd_x(input logic [7:0] op, input logic [23:0] a, input bit with_addr);
        logic [7:0] rx;
        cs_n = 1'b0;
        #100;
        byte_x(op, rx);
        if (with_addr) begin
            byte_x(a[23:16], rx);
            byte_x(a[15:8], rx);
            byte_x(a[7:0], rx);
        end
    endtask

    task automatic cs_release();
        #50;
        cs_n = 1'b1;
        #100;
    endtask

    initial begin
        logic [7:0] rx;
        logic       b;
        int         base, ob, wb;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'hFF;
        mem[16'h0013] = 8'h77;
        mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hC3;

        // Reset values
        #20;
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_do", 32'(miso), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        #20;
        rst_n = 1'b1;
        #40;

        // READ 0x000010, three bytes
        base = rd_cnt;
        cmd_x(8'h03, 24'h000010, 1'b1);
        byte_x(8'h00, rx);
        chk("rd_b0", 32'(rx), 32'hA5);
        chk("rd_oe", 32'(miso_oe), 32'd1);
        byte_x(8'h00, rx);
        chk("rd_b1", 32'(rx), 32'h3C);
        for (int i = 0; i < 7; i++) begin
            bit_x(1'b0, b);
            rx[7-i] = b;
        end
        #30;
        chk("rd_pulses", 32'(rd_cnt - base), 32'd3);
        bit_x(1'b0, b);
        rx[0] = b;
        chk("rd_b2", 32'(rx), 32'hFF);
        chk("rd_a0", 32'(rd_log[base[5:0]]), 32'h0010);
        chk("rd_a1", 32'(rd_log[6'(base + 1)]), 32'h0011);
        chk("rd_a2", 32'(rd_log[6'(base + 2)]), 32'h0012);
        cs_release();
        chk("rd_idle_busy", 32'(busy), 32'd0);
        chk("rd_idle_oe", 32'(miso_oe), 32'd0);

        // Address wrap at 2^16
        base = rd_cnt;
        cmd_x(8'h03, 24'h00FFFF, 1'b1);
        byte_x(8'h00, rx);
        chk("wrap_b0", 32'(rx), 32'h5A);
        byte_x(8'h00, rx);
        chk("wrap_b1", 32'(rx), 32'hC3);
        chk("wrap_a0", 32'(rd_log[base[5:0]]), 32'hFFFF);
        chk("wrap_a1", 32'(rd_log[6'(base + 1)]), 32'h0000);
        cs_release();
        base = rd_cnt;
        cmd_x(8'h03, 24'h12FFFF, 1'b1);
        byte_x(8'h00, rx);
        chk("hi_b0", 32'(rx), 32'h5A);
        chk("hi_a0", 32'(rd_log[base[5:0]]), 32'hFFFF);
        cs_release();

        // RDID
        ob = oe_cnt;
        cmd_x(8'h9F, 24'h0, 1'b0);
        byte_x(8'h00, rx);
        chk("id_b0", 32'(rx), 32'h1C);
        byte_x(8'h00, rx);
        chk("id_b1", 32'(rx), 32'h31);
        byte_x(8'h00, rx);
        chk("id_b2", 32'(rx), 32'h14);
        byte_x(8'h00, rx);
        chk("id_b3", 32'(rx), 32'h00);
        chk("id_oe_seen", 32'(oe_cnt != ob), 32'd1);
        cs_release();

        // RDSR
        cmd_x(8'h05, 24'h0, 1'b0);
        byte_x(8'hFF, rx);
        chk("sr_b0", 32'(rx), 32'h00);
        byte_x(8'hFF, rx);
        chk("sr_b1", 32'(rx), 32'h00);
        cs_release();

        // Unsupported opcode: absorbed with MISO disabled
        ob = oe_cnt;
        cmd_x(8'hAB, 24'h0, 1'b0);
        byte_x(8'h00, rx);
        byte_x(8'h00, rx);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_oe", 32'(oe_cnt - ob), 32'd0);
        cs_release();

        // PAGE PROGRAM with a trailing partial byte
        wb = wr_cnt;
        ob = oe_cnt;
        cmd_x(8'h02, 24'h000100, 1'b1);
        byte_x(8'h11, rx);
        byte_x(8'h22, rx);
        bit_x(1'b1, b);
        bit_x(1'b0, b);
        bit_x(1'b1, b);
        cs_n = 1'b1;
        #40;
        chk("pp_end_busy", 32'(busy), 32'd0);
        chk("pp_end_oe", 32'(miso_oe), 32'd0);
        #60;
`ifdef SPI_TGT_WRITE_EN
        chk("pp_wr_cnt", 32'(wr_cnt - wb), 32'd2);
        chk("pp_a0", 32'(wr_alog[wb[5:0]]), 32'h0100);
        chk("pp_d0", 32'(wr_dlog[wb[5:0]]), 32'h11);
        chk("pp_a1", 32'(wr_alog[6'(wb + 1)]), 32'h0101);
        chk("pp_d1", 32'(wr_dlog[6'(wb + 1)]), 32'h22);
`else
        chk("pp_wr_cnt", 32'(wr_cnt - wb), 32'd0);
        chk("pp_oe", 32'(oe_cnt - ob), 32'd0);
        chk("pp_wdata", 32'(mem_wdata), 32'd0);
`endif

        // Reset in the middle of a READ data byte
        cmd_x(8'h03, 24'h000010, 1'b1);
        for (int i = 0; i < 4; i++) bit_x(1'b0, b);
        rst_n = 1'b0;
        #2;
        chk("mrst_oe", 32'(miso_oe), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_rd", 32'(mem_rd), 32'd0);
        base = rd_cnt;
        #98;
        chk("mrst_no_strobe", 32'(rd_cnt - base), 32'd0);
        rst_n = 1'b1;
        #40;
        byte_x(8'h03, rx);
        chk("mrst_wait_busy", 32'(busy), 32'd0);
        chk("mrst_wait_oe", 32'(miso_oe), 32'd0);
        cs_release();
        cmd_x(8'h03, 24'h000010, 1'b1);
        byte_x(8'h00, rx);
        chk("mrst_b0", 32'(rx), 32'hA5);
        byte_x(8'h00, rx);
        chk("mrst_b1", 32'(rx), 32'h3C);
        cs_release();

        chk("rd_wr_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
